expr_check_arbiter: RTL
=======================

Name: expr_check_arbiter

Overview:
Shares one expression-grammar checker between two byte-stream requesters. Each requester sends one framed expression over a valid/ready handshake, with `last` marking the final byte. The block grants one whole expression at a time using round-robin. It evaluates the grammar digit(op digit)* on the granted stream and returns a one-cycle verdict tagged with the requester id. It sits between the input-capture front ends and the result collector.

Parameters:
MAX_LEN, 16, maximum counted bytes per expression; any longer expression is reported not-ok.

Ports:
clk  input  1  clock, rising edge
clr  input  1  reset, asynchronous, active-high
req0_valid  input  1  requester 0 byte valid
req0_data  input  8  requester 0 ASCII byte
req0_last  input  1  requester 0 final byte of expression
req0_ready  output  1  requester 0 byte accepted this cycle when valid&ready
req1_valid  input  1  requester 1 byte valid
req1_data  input  8  requester 1 ASCII byte
req1_last  input  1  requester 1 final byte of expression
req1_ready  output  1  requester 1 byte accepted
res_valid  output  1  one-cycle result strobe
res_id  output  1  requester the result belongs to
res_ok  output  1  1 = expression well-formed and within MAX_LEN
res_len  output  8  counted bytes of the expression, saturating at 255
busy  output  1  high in RUN and DONE

Behaviour:
- Reset (clr=1, any time, async):
  - Control FSM goes to IDLE; grammar state goes to INIT; len=0.
  - Round-robin pointer rr=0 (requester 0 has priority).
  - All outputs 0.
  - Reset mid-expression aborts it: no result is emitted, and partial input is discarded.
- Control FSM:
  - IDLE: if any reqN_valid, latch owner and go to RUN.
    - If both are valid, owner = rr.
    - If only one is valid, owner = that one.
  - RUN: ready = 1 for the owner only; the other ready = 0.
    - Each accepted byte updates grammar state and len.
    - Owner valid=0 simply stalls; there is no timeout.
    - Accepting a byte with last=1 moves to DONE.
  - DONE: res_valid=1 for exactly one cycle.
    - res_id = owner; res_ok and res_len are valid this cycle.
    - Next state IDLE; rr = ~owner; grammar state cleared to INIT; len cleared to 0.
- Timing:
  - First byte can be accepted no earlier than the cycle after the IDLE cycle that saw valid.
  - Result strobe comes the cycle after the last byte is accepted.
  - Minimum gap between expressions is 2 cycles (DONE, IDLE).
- Grammar state per accepted byte:
  - Digit = 48..57; op = 42 '*' or 43 '+'; any other byte is illegal.
  - INIT: digit -> GOOD; anything else -> BAD.
  - GOOD: op -> WAITNUM; anything else -> BAD.
  - WAITNUM: digit -> GOOD; anything else -> BAD.
  - BAD is absorbing.
- Result rules:
  - res_ok = (final state == GOOD) && (len <= MAX_LEN), where final state includes the last byte.
  - len increments per counted byte and saturates at 255.
- Boundaries:
  - A non-owner's valid is ignored while busy; its data must be held by the sender.
  - Single-byte digit expressions are ok; an expression ending on an op is not ok.
  - No expression can be empty, because last always travels with a byte.
  - res_* other than res_valid hold their last value between strobes.

Optional Feature:
SPACE_SKIP_EN
- Defined: byte 32 (space) is accepted normally but does not change grammar state and is not counted in len.
- Undefined: space is an illegal byte and sends the grammar state to BAD.
- Either way, last=1 on a space byte still ends the expression.

Test Plan:
1. req0 sends 49,43,50,42,51 ("1+2*3"), last on 51 -> one res_valid cycle with id=0, ok=1, len=5; req1_ready stays 0 throughout.
2. req1 sends "12" -> id=1, ok=0, len=2. Separately, req1 sends "1+" -> ok=0, len=2, and "+1" -> ok=0, len=2.
3. After reset, req0 and req1 are both valid with "7" -> req0 served first (id=0, ok=1, len=1), then req1 (id=1, ok=1). The two readys are never high together.
4. MAX_LEN=4, "1+2*3" -> ok=0, len=5. MAX_LEN=4, "1+2" -> ok=1, len=3.
5. req0 starts "1+2*3"; clr pulses after 2 bytes accepted -> busy=0 and both readys 0 immediately, no res_valid. Then req1 sends "5" -> id=1, ok=1, len=1.
6. "1 + 2" (49,32,43,32,50): with SPACE_SKIP_EN -> ok=1, len=3; without -> ok=0, len=5.

Source files
------------

// File: rtl/expr_check_arbiter.sv
// Round-robin arbiter that shares one digit(op digit)* grammar checker between two byte streams.
// Optional build macro SPACE_SKIP_EN: spaces are accepted but neither parsed nor counted.
module expr_check_arbiter #(
    parameter int unsigned MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       res_valid,
    output logic       res_id,
    output logic       res_ok,
    output logic [7:0] res_len,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic [1:0] {GInit, GGood, GWaitNum, GBad} gram_e;

    state_e     r_state, w_state_nxt;
    gram_e      r_gram, w_gram_nxt, w_gram_step;
    logic       r_owner, w_owner_nxt;
    logic       r_rr, w_rr_nxt;
    logic [7:0] r_len, w_len_nxt, w_len_step;
    logic       r_res_id, w_res_id_nxt;
    logic       r_res_ok, w_res_ok_nxt;
    logic [7:0] r_res_len, w_res_len_nxt;

    logic       w_valid;
    logic [7:0] w_data;
    logic       w_last;
    logic       w_accept;
    logic       w_is_digit;
    logic       w_is_op;
    logic       w_skip;
    logic       w_ok_step;

    // Only the owner's stream reaches the checker.
    assign w_valid  = r_owner ? req1_valid : req0_valid;
    assign w_data   = r_owner ? req1_data : req0_data;
    assign w_last   = r_owner ? req1_last : req0_last;
    assign w_accept = (r_state == StRun) && w_valid;

    assign w_is_digit = (w_data >= 8'd48) && (w_data <= 8'd57);
    assign w_is_op    = (w_data == 8'd42) || (w_data == 8'd43);

`ifdef SPACE_SKIP_EN
    assign w_skip = (w_data == 8'd32);
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        w_gram_step = r_gram;
        if (!w_skip) begin
            unique case (r_gram)
                GInit:    w_gram_step = w_is_digit ? GGood : GBad;
                GGood:    w_gram_step = w_is_op ? GWaitNum : GBad;
                GWaitNum: w_gram_step = w_is_digit ? GGood : GBad;
                default:  w_gram_step = GBad;
            endcase
        end
    end

    always_comb begin
        w_len_step = r_len;
        if (!w_skip && (r_len != 8'd255)) begin
            w_len_step = r_len + 8'd1;
        end
    end

    // Verdict includes the byte being accepted this cycle.
    assign w_ok_step = (w_gram_step == GGood) && (32'(w_len_step) <= MAX_LEN);

    always_comb begin
        w_state_nxt   = r_state;
        w_gram_nxt    = r_gram;
        w_owner_nxt   = r_owner;
        w_rr_nxt      = r_rr;
        w_len_nxt     = r_len;
        w_res_id_nxt  = r_res_id;
        w_res_ok_nxt  = r_res_ok;
        w_res_len_nxt = r_res_len;
        unique case (r_state)
            StIdle: begin
                if (req0_valid || req1_valid) begin
                    w_owner_nxt = (req0_valid && req1_valid) ? r_rr : req1_valid;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (w_accept) begin
                    w_gram_nxt = w_gram_step;
                    w_len_nxt  = w_len_step;
                    if (w_last) begin
                        w_state_nxt   = StDone;
                        w_res_id_nxt  = r_owner;
                        w_res_ok_nxt  = w_ok_step;
                        w_res_len_nxt = w_len_step;
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
                w_rr_nxt    = ~r_owner;
                w_gram_nxt  = GInit;
                w_len_nxt   = 8'd0;
            end
            default: begin
                w_state_nxt = StIdle;
                w_gram_nxt  = GInit;
                w_len_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= StIdle;
            r_gram    <= GInit;
            r_owner   <= 1'b0;
            r_rr      <= 1'b0;
            r_len     <= 8'd0;
            r_res_id  <= 1'b0;
            r_res_ok  <= 1'b0;
            r_res_len <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_gram    <= w_gram_nxt;
            r_owner   <= w_owner_nxt;
            r_rr      <= w_rr_nxt;
            r_len     <= w_len_nxt;
            r_res_id  <= w_res_id_nxt;
            r_res_ok  <= w_res_ok_nxt;
            r_res_len <= w_res_len_nxt;
        end
    end

    assign req0_ready = (r_state == StRun) && !r_owner;
    assign req1_ready = (r_state == StRun) && r_owner;
    assign res_valid  = (r_state == StDone);
    assign res_id     = r_res_id;
    assign res_ok     = r_res_ok;
    assign res_len    = r_res_len;
    assign busy       = (r_state != StIdle);

endmodule
